// File: rtl/cpu_pkg.sv
// Shared constants and types for the cpu front end: instruction width, streamer
// run modes and the streamer sequencer states.
package cpu_pkg;

    localparam int INSTR_WIDTH = 32;

    typedef enum logic [1:0] {
        RUN_ONCE    = 2'b00,
        LOOP        = 2'b01,
        SINGLE_STEP = 2'b10
    } streamer_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_PRESENT   = 3'd2,
        ST_STEP_WAIT = 3'd3,
        ST_DONE      = 3'd4
    } streamer_state_t;

    // The unused encoding 2'b11 behaves as a plain run-once.
    function automatic streamer_mode_t decode_mode(input logic [1:0] mode_bits);
        case (mode_bits)
            2'b01:   return LOOP;
            2'b10:   return SINGLE_STEP;
            default: return RUN_ONCE;
        endcase
    endfunction

endpackage

// File: rtl/instruction_memory.sv
// Program store: one synchronous write port and one registered read port with
// a read enable, so the read register holds its word whenever no read issues.
module instruction_memory #(
    parameter int DEPTH       = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int ADDR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   wr_en,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic [INSTR_WIDTH-1:0] wr_data,
    input  logic                   rd_en,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic [INSTR_WIDTH-1:0] rd_data
);

    logic [INSTR_WIDTH-1:0] mem [DEPTH];
    logic [INSTR_WIDTH-1:0] rd_data_reg;

    // Array contents are deliberately left out of reset so programs survive it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/instruction_streamer.sv
// Program store plus sequencer: presents one instruction at a time to the cpu
// under ready/valid flow control, with run-once, loop and single-step modes.
module instruction_streamer #(
    parameter int                     INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
    parameter int                     DEPTH       = 64,
    parameter int                     ADDR_WIDTH  = $clog2(DEPTH),
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = '1
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic                   load_enable_in,
    input  logic [ADDR_WIDTH-1:0]  load_address_in,
    input  logic [INSTR_WIDTH-1:0] load_data_in,
    input  logic [ADDR_WIDTH:0]    program_length_in,
    input  logic [1:0]             mode_in,
    input  logic                   start_in,
    input  logic                   step_in,
    input  logic                   instruction_ready_in,
    output logic [INSTR_WIDTH-1:0] instruction_out,
    output logic                   instruction_valid_out,
    output logic [ADDR_WIDTH-1:0]  pc_out,
    output logic                   busy_out,
    output logic                   done_out
);

    import cpu_pkg::*;

    localparam int LEN_W = ADDR_WIDTH + 1;

    streamer_state_t        state_reg, state_next;
    streamer_mode_t         mode_reg, mode_next;
    logic [ADDR_WIDTH-1:0]  pc_reg, pc_next;
    logic [LEN_W-1:0]       length_reg, length_next;
    logic                   valid_reg, valid_next;

    logic                   mem_we;
    logic                   rd_en;
    logic [ADDR_WIDTH-1:0]  rd_addr;
    logic [INSTR_WIDTH-1:0] rd_data;

    logic                   handshake;
    logic                   last_word;
    logic [ADDR_WIDTH-1:0]  pc_inc;
    logic [LEN_W-1:0]       length_clamped;

    // The memory read register doubles as the instruction output register.
    instruction_memory #(
        .DEPTH       (DEPTH),
        .INSTR_WIDTH (INSTR_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_memory (
        .clk     (clock_in),
        .srst    (reset_in),
        .wr_en   (mem_we),
        .wr_addr (load_address_in),
        .wr_data (load_data_in),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign handshake      = valid_reg && instruction_ready_in;
    assign pc_inc         = pc_reg + ADDR_WIDTH'(1);
    assign last_word      = (LEN_W'(pc_reg) + LEN_W'(1)) == length_reg;
    assign length_clamped = (program_length_in > LEN_W'(DEPTH)) ? LEN_W'(DEPTH)
                                                                 : program_length_in;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_reg  <= ST_IDLE;
            mode_reg   <= RUN_ONCE;
            pc_reg     <= '0;
            length_reg <= '0;
            valid_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            mode_reg   <= mode_next;
            pc_reg     <= pc_next;
            length_reg <= length_next;
            valid_reg  <= valid_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        mode_next   = mode_reg;
        pc_next     = pc_reg;
        length_next = length_reg;
        valid_next  = 1'b0;
        mem_we      = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = pc_reg;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                mem_we = load_enable_in;
                if (start_in) begin
                    if (program_length_in == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        length_next = length_clamped;
                        mode_next   = decode_mode(mode_in);
                        pc_next     = '0;
                        state_next  = ST_FETCH;
                    end
                end
            end

            ST_FETCH: begin
                rd_en      = 1'b1;
                rd_addr    = pc_reg;
                valid_next = 1'b1;
                state_next = ST_PRESENT;
            end

            ST_PRESENT: begin
                valid_next = 1'b1;
                if (handshake) begin
                    if (rd_data == HALT_WORD) begin
                        valid_next = 1'b0;
                        state_next = ST_DONE;
                    end else if (last_word) begin
                        if (mode_reg == LOOP) begin
                            // Wrap issues the read of word 0 now, so no bubble.
                            pc_next = '0;
                            rd_en   = 1'b1;
                            rd_addr = '0;
                        end else begin
                            valid_next = 1'b0;
                            state_next = ST_DONE;
                        end
                    end else if (mode_reg == SINGLE_STEP) begin
                        pc_next    = pc_inc;
                        valid_next = 1'b0;
                        state_next = ST_STEP_WAIT;
                    end else begin
                        pc_next = pc_inc;
                        rd_en   = 1'b1;
                        rd_addr = pc_inc;
                    end
                end
            end

            ST_STEP_WAIT: begin
                if (step_in) begin
                    state_next = ST_FETCH;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign instruction_out       = rd_data;
    assign instruction_valid_out = valid_reg;
    assign pc_out                = pc_reg;
    assign busy_out              = (state_reg == ST_FETCH) || (state_reg == ST_PRESENT)
                                   || (state_reg == ST_STEP_WAIT);
    assign done_out              = (state_reg == ST_DONE);

endmodule

// File: tb/tb_instruction_streamer.sv
// Scoreboard bench for instruction_streamer: expected (pc, word) pairs are derived
// from a software copy of program memory; a negedge monitor checks each handshake.
module tb_instruction_streamer;

    localparam int             W    = 32;
    localparam int             D    = 64;
    localparam int             AW   = 6;
    localparam logic [W-1:0]   HALT = '1;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [W-1:0]  load_data;
    logic [AW:0]   len;
    logic [1:0]    mode;
    logic          start;
    logic          step;
    logic          ready;
    logic [W-1:0]  instr;
    logic          valid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    instruction_streamer #(
        .INSTR_WIDTH (W),
        .DEPTH       (D)
    ) dut (
        .clock_in              (clk),
        .reset_in              (reset),
        .load_enable_in        (load_en),
        .load_address_in       (load_addr),
        .load_data_in          (load_data),
        .program_length_in     (len),
        .mode_in               (mode),
        .start_in              (start),
        .step_in               (step),
        .instruction_ready_in  (ready),
        .instruction_out       (instr),
        .instruction_valid_out (valid),
        .pc_out                (pc),
        .busy_out              (busy),
        .done_out              (done)
    );

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [W-1:0]  instr;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] model_mem [D];
    int           checks   = 0;
    int           passes   = 0;
    int           hs_count = 0;
    int           cycle    = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: pops one expectation per handshake and checks stall stability.
    logic          stall_prev = 1'b0;
    logic [W-1:0]  stall_instr;
    logic [AW-1:0] stall_pc;
    exp_t          mon_e;

    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 64'(valid), 64'(1'b1));
                check("stall_instr", 64'(instr), 64'(stall_instr));
                check("stall_pc", 64'(pc), 64'(stall_pc));
            end
            stall_prev  = valid && !ready;
            stall_instr = instr;
            stall_pc    = pc;
            if (valid && ready) begin
                hs_count++;
                check("sb_expected_present", 64'(exp_q.size() != 0), 64'(1'b1));
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    $display("handshake %0d: pc=%0d instr=%08h (expected pc=%0d instr=%08h)",
                             hs_count, pc, instr, mon_e.pc, mon_e.instr);
                    check("sb_pc", 64'(pc), 64'(mon_e.pc));
                    check("sb_instr", 64'(instr), 64'(mon_e.instr));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input int idx);
        exp_t e;
        e.pc    = AW'(idx);
        e.instr = model_mem[idx];
        exp_q.push_back(e);
    endtask

    // A run delivers words 0..min(len,DEPTH)-1 in order, stopping after a halt word.
    task automatic push_run(input int n_words);
        int n;
        n = (n_words > D) ? D : n_words;
        for (int i = 0; i < n; i++) begin
            push_word(i);
            if (model_mem[i] == HALT) break;
        end
    endtask

    task automatic load_word(input int addr, input logic [W-1:0] data);
        load_en   = 1'b1;
        load_addr = AW'(addr);
        load_data = data;
        tick();
        load_en = 1'b0;
        model_mem[addr] = data;
    endtask

    task automatic start_run(input int n_words, input logic [1:0] m);
        start = 1'b1;
        len   = (AW + 1)'(n_words);
        mode  = m;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_hs(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (hs_count >= target) break;
            tick();
        end
        check("hs_within_budget", 64'(hs_count >= target), 64'(1'b1));
    endtask

    task automatic wait_done(input int budget, input bit randomize);
        for (int i = 0; i < budget; i++) begin
            if (done) break;
            tick();
            if (randomize) begin
                ready = ($urandom_range(0, 3) != 0);
                step  = ($urandom_range(0, 2) == 0);
            end
        end
        step = 1'b0;
        check("done_within_budget", 64'(done), 64'(1'b1));
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        w = $urandom;
        if (w == HALT) w = 32'h1234_5678;
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int           hs0;
        int           c1;
        int           c9;
        int           n;
        int           a;
        logic [W-1:0] saved;

        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        len = '0; mode = 2'b00; start = 1'b0; step = 1'b0; ready = 1'b0;
        tick(); tick();
        check("reset_valid", 64'(valid), 64'(1'b0));
        check("reset_pc", 64'(pc), 64'(0));
        check("reset_busy", 64'(busy), 64'(1'b0));
        check("reset_done", 64'(done), 64'(1'b0));
        check("reset_instr", 64'(instr), 64'(0));
        reset = 1'b0;
        tick();

        for (int i = 0; i < D; i++) load_word(i, rand_word());

        // Run-once, ready high: latency, four consecutive words, done after last.
        ready = 1'b1;
        push_run(4);
        start_run(4, 2'b00);
        check("fetch_valid_low", 64'(valid), 64'(1'b0));
        check("fetch_busy", 64'(busy), 64'(1'b1));
        tick();
        check("first_valid", 64'(valid), 64'(1'b1));
        check("first_pc", 64'(pc), 64'(0));
        check("first_instr", 64'(instr), 64'(model_mem[0]));
        hs0 = hs_count;
        c1  = cycle;
        wait_hs(hs0 + 4, 20);
        check("run_once_cycles", 64'(cycle - c1), 64'(4));
        check("done_after_last", 64'(done), 64'(1'b1));
        check("valid_after_last", 64'(valid), 64'(1'b0));
        check("queue_drained_1", 64'(exp_q.size()), 64'(0));

        // Back-pressure for three cycles while word 1 is presented.
        hs0 = hs_count;
        push_run(4);
        start_run(4, 2'b00);
        wait_hs(hs0 + 1, 20);
        ready = 1'b0;
        check("stall_pc_is_1", 64'(pc), 64'(1));
        check("stall_word_a1", 64'(instr), 64'(model_mem[1]));
        tick(); tick(); tick();
        ready = 1'b1;
        wait_done(20, 1'b0);
        check("queue_drained_2", 64'(exp_q.size()), 64'(0));

        // Loop mode, length 3, nine words with no bubble at the wrap.
        hs0 = hs_count;
        for (int i = 0; i < 9; i++) push_word(i % 3);
        start_run(3, 2'b01);
        wait_hs(hs0 + 1, 20);
        c1 = cycle;
        wait_hs(hs0 + 9, 40);
        c9 = cycle;
        ready = 1'b0;
        check("loop_no_bubble", 64'(c9 - c1), 64'(8));
        check("loop_still_busy", 64'(busy), 64'(1'b1));
        check("queue_drained_3", 64'(exp_q.size()), 64'(0));

        // Reset mid-run aborts at once.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_valid", 64'(valid), 64'(1'b0));
        check("abort_pc", 64'(pc), 64'(0));
        check("abort_busy", 64'(busy), 64'(1'b0));
        check("abort_done", 64'(done), 64'(1'b0));

        // Halt word at address 2 ends the run after delivering it.
        saved = model_mem[2];
        load_word(2, HALT);
        ready = 1'b1;
        push_run(8);
        start_run(8, 2'b00);
        wait_done(30, 1'b0);
        check("queue_drained_4", 64'(exp_q.size()), 64'(0));
        tick(); tick(); tick();
        check("halt_pc_held", 64'(pc), 64'(2));
        check("halt_word_held", 64'(instr), 64'(HALT));
        check("halt_valid_low", 64'(valid), 64'(1'b0));
        load_word(2, saved);

        // Single-step, length 2.
        hs0 = hs_count;
        push_run(2);
        start_run(2, 2'b10);
        wait_hs(hs0 + 1, 20);
        check("step_wait_valid", 64'(valid), 64'(1'b0));
        check("step_wait_pc", 64'(pc), 64'(1));
        tick(); tick(); tick();
        check("step_wait_still_low", 64'(valid), 64'(1'b0));
        check("step_wait_busy", 64'(busy), 64'(1'b1));
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step_fetch_valid", 64'(valid), 64'(1'b0));
        tick();
        check("step_valid", 64'(valid), 64'(1'b1));
        check("step_instr", 64'(instr), 64'(model_mem[1]));
        wait_done(10, 1'b0);
        check("queue_drained_5", 64'(exp_q.size()), 64'(0));

        // Loads and starts while busy are dropped; memory is retained.
        ready = 1'b0;
        push_run(4);
        start_run(4, 2'b00);
        tick(); tick();
        load_en = 1'b1; load_addr = '0; load_data = ~model_mem[0]; start = 1'b1;
        tick();
        load_en = 1'b0; start = 1'b0;
        ready = 1'b1;
        wait_done(20, 1'b0);
        push_run(4);
        start_run(4, 2'b00);
        wait_done(20, 1'b0);
        check("queue_drained_6", 64'(exp_q.size()), 64'(0));

        // Load and start in the same cycle: the new word is fetched.
        model_mem[0] = rand_word();
        load_en = 1'b1; load_addr = '0; load_data = model_mem[0];
        push_run(2);
        start_run(2, 2'b00);
        load_en = 1'b0;
        wait_done(20, 1'b0);
        check("queue_drained_7", 64'(exp_q.size()), 64'(0));

        // Randomised runs: random contents, halts, lengths (incl. 0 and >DEPTH), modes.
        for (int r = 0; r < 14; r++) begin
            for (int k = 0; k < 4; k++) begin
                a = $urandom_range(0, D - 1);
                load_word(a, ($urandom_range(0, 3) == 0) ? HALT : rand_word());
            end
            case ($urandom_range(0, 3))
                0: n = 0;
                1: n = $urandom_range(D, 2 * D - 1);
                default: n = $urandom_range(1, D);
            endcase
            a = $urandom_range(0, D - 1);
            model_mem[a] = rand_word();
            load_en = 1'b1; load_addr = AW'(a); load_data = model_mem[a];
            push_run(n);
            case ($urandom_range(0, 2))
                0: start_run(n, 2'b00);
                1: start_run(n, 2'b10);
                default: start_run(n, 2'b11);
            endcase
            load_en = 1'b0;
            if (n == 0) begin
                check("zero_len_done", 64'(done), 64'(1'b1));
                check("zero_len_busy", 64'(busy), 64'(1'b0));
            end else begin
                wait_done(3000, 1'b1);
            end
            check("rand_queue_drained", 64'(exp_q.size()), 64'(0));
            ready = 1'b1;
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
